// File: rtl/piano_pkg.sv
// Shared constants for the UART piano recorder.
// Default rest character, note-length divisor and LED bit positions.
package piano_pkg;

  localparam logic [7:0] REST_CHAR_DEF = 8'h20;
  localparam int         NOTE_DIV      = 5;

  localparam int LED_REC   = 0;
  localparam int LED_OVF   = 1;
  localparam int LED_NOTE  = 2;
  localparam int LED_EMPTY = 3;

endpackage

// File: rtl/piano_fifo.sv
// Synchronous FIFO with one-cycle registered read data.
// Ports: clk, rst, wr_en/din/full, rd_en/dout/empty.
module piano_fifo #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CMAX = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             wr_ok;
  logic             rd_ok;

  assign full  = (count == CMAX);
  assign empty = (count == '0);
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      dout  <= '0;
    end else begin
      if (wr_ok) begin
        wptr <= (wptr == LAST) ? '0 : wptr + AW'(1);
      end
      if (rd_ok) begin
        rptr <= (rptr == LAST) ? '0 : rptr + AW'(1);
        dout <= mem[rptr];
      end
      unique case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/piano_note_recorder.sv
// Samples the held key once per note period, queues chars, drains to UART TX.
// Ports: clk, rst, buttons, note_code/note_active, leds, ua_tx_din/wr_en/full.
module piano_note_recorder
  import piano_pkg::*;
#(
  parameter int         CYCLES_PER_SECOND = 125_000_000,
  parameter int         FIFO_DEPTH        = 256,
  parameter logic [7:0] REST_CHAR         = REST_CHAR_DEF,
  parameter int         MAX_RESTS         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] buttons,
  input  logic [7:0] note_code,
  input  logic       note_active,
  output logic [5:0] leds,
  output logic [7:0] ua_tx_din,
  output logic       ua_tx_wr_en,
  input  logic       ua_tx_full
);

  localparam int NLW = 2 * $clog2(CYCLES_PER_SECOND) + 1;
  localparam int RW  = $clog2(MAX_RESTS + 1);

  localparam logic [NLW-1:0] NL_RST =
    NLW'(CYCLES_PER_SECOND / NOTE_DIV);
  localparam logic [NLW-1:0] NL_MAX = '1;
  localparam logic [NLW-1:0] NL_ONE = NLW'(1);
  localparam logic [RW-1:0]  R_MAX  = RW'(MAX_RESTS);

  logic [NLW-1:0] note_length;
  logic [NLW-1:0] nl_d;
  logic [NLW-1:0] counter;
  logic           recording;
  logic           overflow;
  logic           last_note;
  logic [RW-1:0]  rest_run;

  logic           dbl;
  logic           hlv;
  logic           cnt_hit;
  logic           tick;
  logic           rest_ok;
  logic           push;
  logic [7:0]     push_char;

  logic           fifo_wr;
  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_rd;
  logic [7:0]     fifo_dout;

  logic           rd_pending;
  logic           out_valid;
  logic [7:0]     out_data;

  assign dbl = buttons[0] & ~buttons[1];
  assign hlv = buttons[1] & ~buttons[0];

  always_comb begin
    nl_d = note_length;
    unique case (1'b1)
      dbl: begin
        nl_d = note_length[NLW-1] ? NL_MAX
                                  : note_length << 1;
      end
      hlv: begin
        nl_d = (note_length > NL_ONE) ? note_length >> 1
                                      : NL_ONE;
      end
      default: nl_d = note_length;
    endcase
  end

  // ">=" so a halving in mid-period ends the period at once
  assign cnt_hit   = counter >= (note_length - NL_ONE);
  assign tick      = recording & cnt_hit;
  assign rest_ok   = rest_run < R_MAX;
  assign push      = tick & (note_active | rest_ok);
  assign push_char = note_active ? note_code : REST_CHAR;
  assign fifo_wr   = push & ~fifo_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      note_length <= NL_RST;
      counter     <= '0;
      recording   <= 1'b0;
      overflow    <= 1'b0;
      last_note   <= 1'b0;
      rest_run    <= '0;
    end else begin
      note_length <= nl_d;

      if (tick) begin
        last_note <= note_active;
        if (note_active) begin
          rest_run <= '0;
        end else if (rest_ok) begin
          rest_run <= rest_run + RW'(1);
        end
        if (push & fifo_full) begin
          overflow <= 1'b1;
        end
      end

      if (buttons[2]) begin
        recording <= ~recording;
        counter   <= '0;
        if (!recording) begin
          rest_run <= '0;
          overflow <= 1'b0;
        end
      end else if (recording) begin
        counter <= cnt_hit ? '0 : counter + NLW'(1);
      end
    end
  end

  piano_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (fifo_wr),
    .din   (push_char),
    .full  (fifo_full),
    .rd_en (fifo_rd),
    .dout  (fifo_dout),
    .empty (fifo_empty)
  );

  // one read in flight at a time; output reg must be free
  assign fifo_rd     = ~fifo_empty & ~out_valid & ~rd_pending;
  assign ua_tx_wr_en = out_valid & ~ua_tx_full;
  assign ua_tx_din   = out_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pending <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      rd_pending <= fifo_rd;
      if (rd_pending) begin
        out_data  <= fifo_dout;
        out_valid <= 1'b1;
      end else if (ua_tx_wr_en) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    leds            = '0;
    leds[LED_REC]   = recording;
    leds[LED_OVF]   = overflow;
    leds[LED_NOTE]  = last_note;
    leds[LED_EMPTY] = fifo_empty;
  end

endmodule

// File: tb/tb_piano_note_recorder.sv
// Scoreboard bench for piano_note_recorder.
// Stimulus queues expected chars; a negedge monitor checks UART writes.
module tb_piano_note_recorder;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] buttons;
  logic [7:0] note_code;
  logic       note_active;
  logic [5:0] leds;
  logic [7:0] ua_tx_din;
  logic       ua_tx_wr_en;
  logic       ua_tx_full;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] exp_q [$];

  localparam logic [2:0] B_DBL = 3'b001;
  localparam logic [2:0] B_HLV = 3'b010;
  localparam logic [2:0] B_REC = 3'b100;

  always #5 clk = ~clk;

  piano_note_recorder #(
    .CYCLES_PER_SECOND (50),
    .FIFO_DEPTH        (4),
    .REST_CHAR         (8'h20),
    .MAX_RESTS         (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .buttons     (buttons),
    .note_code   (note_code),
    .note_active (note_active),
    .leds        (leds),
    .ua_tx_din   (ua_tx_din),
    .ua_tx_wr_en (ua_tx_wr_en),
    .ua_tx_full  (ua_tx_full)
  );

  always @(negedge clk) begin
    if (ua_tx_wr_en === 1'b1) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got %02h, none expected",
                 ua_tx_din);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (ua_tx_din !== e) begin
          n_fail++;
          $display("FAIL tx_char: got %02h expected %02h",
                   ua_tx_din, e);
        end
      end
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [2:0] b);
    buttons = b;
    cyc(1);
    buttons = '0;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    buttons     = '0;
    note_active = 1'b0;
    note_code   = '0;
    ua_tx_full  = 1'b0;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic push_n(input logic [7:0] c, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(c);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      cyc(1);
      k++;
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d chars left, expected 0",
               name, exp_q.size());
      exp_q.delete();
    end
    cyc(15);
  endtask

  initial begin
    do_reset();
    chk("reset_leds", 32'(leds), 32'h08);
    chk("reset_wr_en", 32'(ua_tx_wr_en), 0);
    chk("reset_din", 32'(ua_tx_din), 0);
    chk("reset_nl", 32'(dut.note_length), 10);

    // 1: hold 'a' for three periods
    push_n(8'h61, 3);
    note_code   = 8'h61;
    note_active = 1'b1;
    press(B_REC);
    chk("t1_rec_on", 32'(leds[0]), 1);
    cyc(30);
    chk("t1_rec", 32'(leds[0]), 1);
    chk("t1_note", 32'(leds[2]), 1);
    press(B_REC);
    chk("t1_rec_off", 32'(leds[0]), 0);
    drain("t1");
    chk("t1_empty", 32'(leds[3]), 1);

    // 2: silence capped at four rests, then 'b'
    do_reset();
    push_n(8'h20, 4);
    push_n(8'h62, 1);
    press(B_REC);
    cyc(80);
    chk("t2_note_lo", 32'(leds[2]), 0);
    note_code   = 8'h62;
    note_active = 1'b1;
    cyc(10);
    press(B_REC);
    chk("t2_note_hi", 32'(leds[2]), 1);
    chk("t2_ovf", 32'(leds[1]), 0);
    drain("t2");

    // 3: halved period, then length limits
    do_reset();
    press(B_HLV);
    chk("t3_nl_half", 32'(dut.note_length), 5);
    push_n(8'h63, 5);
    note_code   = 8'h63;
    note_active = 1'b1;
    press(B_REC);
    cyc(25);
    press(B_REC);
    drain("t3");
    do_reset();
    for (int i = 0; i < 4; i++) press(B_HLV);
    chk("t3_nl_floor", 32'(dut.note_length), 1);
    do_reset();
    press(B_DBL);
    chk("t3_nl_dbl", 32'(dut.note_length), 20);
    press(B_DBL | B_HLV);
    chk("t3_nl_both", 32'(dut.note_length), 20);

    // 4: TX blocked, overflow, then 4 FIFO + 1 reg chars
    do_reset();
    ua_tx_full  = 1'b1;
    note_active = 1'b1;
    for (int i = 0; i < 5; i++) push_n(8'h64 + 8'(i), 1);
    press(B_REC);
    for (int i = 0; i < 8; i++) begin
      note_code = 8'h64 + 8'(i);
      cyc(10);
    end
    press(B_REC);
    chk("t4_ovf", 32'(leds[1]), 1);
    chk("t4_not_empty", 32'(leds[3]), 0);
    chk("t4_blocked", 32'(ua_tx_wr_en), 0);
    ua_tx_full = 1'b0;
    drain("t4");
    chk("t4_ovf_sticky", 32'(leds[1]), 1);
    press(B_REC);
    chk("t4_ovf_clr", 32'(leds[1]), 0);
    press(B_REC);
    cyc(5);

    // 5: TX full toggling while draining
    do_reset();
    push_n(8'h65, 1);
    push_n(8'h66, 1);
    push_n(8'h67, 1);
    note_active = 1'b1;
    fork
      begin
        repeat (80) begin
          @(posedge clk);
          #1;
          ua_tx_full = ~ua_tx_full;
        end
        ua_tx_full = 1'b0;
      end
      begin
        note_code = 8'h65;
        press(B_REC);
        cyc(10);
        note_code = 8'h66;
        cyc(10);
        note_code = 8'h67;
        cyc(10);
        press(B_REC);
      end
    join
    drain("t5");

    // 6: reset with chars queued discards them
    do_reset();
    ua_tx_full  = 1'b1;
    note_code   = 8'h69;
    note_active = 1'b1;
    press(B_REC);
    cyc(30);
    chk("t6_queued", 32'(leds[3]), 0);
    rst = 1'b1;
    cyc(1);
    rst        = 1'b0;
    ua_tx_full = 1'b0;
    chk("t6_wr_en", 32'(ua_tx_wr_en), 0);
    chk("t6_leds", 32'(leds), 32'h08);
    cyc(40);
    chk("t6_quiet", 32'(leds[3]), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
